// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters plus an in-flight prediction queue.
// Optional statistics counters are built when BP_STATS_EN is defined.
module branch_predictor #(
    parameter int INDEX_W = 4,
    parameter int QDEPTH  = 4
) (
    input  logic        clk_i,
    input  logic        rsn_i,
    input  logic [31:0] fetch_pc_i,
    input  logic        fetch_valid_i,
    input  logic        flush_i,
    input  logic        alu_valid_i,
    input  logic        alu_branch_i,
    input  logic        alu_jumps_i,
    input  logic [31:0] alu_pc_jmp_i,
    output logic        bp_prediction_o,
    output logic        bp_taken_o,
    output logic [31:0] bp_pred_pc_o,
    output logic        bp_error_o,
    output logic        bp_full_o,
    output logic [31:0] bp_br_cnt_o,
    output logic [31:0] bp_miss_cnt_o
);

    localparam int ENTRIES = 1 << INDEX_W;
    localparam int TAG_W   = 30 - INDEX_W;
    localparam int PTR_W   = $clog2(QDEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] QDEPTH_C = CNT_W'(QDEPTH);

    logic              tbl_valid [ENTRIES];
    logic [TAG_W-1:0]  tbl_tag   [ENTRIES];
    logic [1:0]        tbl_ctr   [ENTRIES];
    logic [31:0]       tbl_tgt   [ENTRIES];

    logic [31:0]       q_pc      [QDEPTH];
    logic              q_taken   [QDEPTH];
    logic [31:0]       q_tgt     [QDEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count, count_n;

    // ---------------- lookup (fetch side) ----------------
    logic [INDEX_W-1:0] lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic               lk_hit;

    assign lk_idx = fetch_pc_i[INDEX_W+1:2];
    assign lk_tag = fetch_pc_i[31:INDEX_W+2];
    assign lk_hit = tbl_valid[lk_idx] && (tbl_tag[lk_idx] == lk_tag);

    assign bp_prediction_o = lk_hit;
    assign bp_taken_o      = lk_hit & tbl_ctr[lk_idx][1];
    assign bp_pred_pc_o    = lk_hit ? tbl_tgt[lk_idx] : 32'h0;

    // ---------------- queue head and resolution ----------------
    logic        q_empty, q_full;
    logic [31:0] head_pc, head_tgt;
    logic        head_taken;
    logic        actual, mispredict, push, pop;

    assign q_empty = (count == '0);
    assign q_full  = (count == QDEPTH_C);
    assign bp_full_o = q_full;

    // An empty queue presents a not-taken head at pc 0 so a stray resolve still flags a taken branch.
    assign head_pc    = q_empty ? 32'h0 : q_pc[rd_ptr];
    assign head_taken = q_empty ? 1'b0  : q_taken[rd_ptr];
    assign head_tgt   = q_empty ? 32'h0 : q_tgt[rd_ptr];

    assign actual     = alu_branch_i & alu_jumps_i;
    assign mispredict = alu_valid_i &
                        ((head_taken != actual) ||
                         (head_taken & actual & (head_tgt != alu_pc_jmp_i)));
    assign bp_error_o = mispredict;

    // fetch_valid_i and alu_valid_i are one-cycle strobes: a push is accepted only when the queue
    // has room (or frees a slot the same cycle) and no flush/mispredict is redirecting fetch;
    // a pop is accepted whenever the queue is non-empty.
    assign pop  = alu_valid_i & ~q_empty;
    assign push = fetch_valid_i & (~q_full | pop) & ~flush_i & ~mispredict;

    always_comb begin
        count_n = count;
        case ({push, pop})
            2'b10:   count_n = count + CNT_W'(1);
            2'b01:   count_n = count - CNT_W'(1);
            default: count_n = count;
        endcase
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i || mispredict) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_n;
        end
    end

    // Payload needs no reset: it is only observed through count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            q_pc[wr_ptr]    <= fetch_pc_i;
            q_taken[wr_ptr] <= bp_taken_o;
            q_tgt[wr_ptr]   <= bp_pred_pc_o;
        end
    end

    // ---------------- table update (resolution side) ----------------
    logic [INDEX_W-1:0] up_idx;
    logic [TAG_W-1:0]   up_tag;
    logic               up_hit;

    assign up_idx = head_pc[INDEX_W+1:2];
    assign up_tag = head_pc[31:INDEX_W+2];
    assign up_hit = tbl_valid[up_idx] && (tbl_tag[up_idx] == up_tag);

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_valid[i] <= 1'b0;
                tbl_tag[i]   <= '0;
                tbl_ctr[i]   <= 2'b01;
                tbl_tgt[i]   <= 32'h0;
            end
        end else if (pop) begin
            if (alu_branch_i) begin
                if (!up_hit) begin
                    tbl_valid[up_idx] <= 1'b1;
                    tbl_tag[up_idx]   <= up_tag;
                    tbl_ctr[up_idx]   <= actual ? 2'b10 : 2'b01;
                    if (actual) tbl_tgt[up_idx] <= alu_pc_jmp_i;
                end else if (actual) begin
                    if (tbl_ctr[up_idx] != 2'b11) tbl_ctr[up_idx] <= tbl_ctr[up_idx] + 2'b01;
                    tbl_tgt[up_idx] <= alu_pc_jmp_i;
                end else begin
                    if (tbl_ctr[up_idx] != 2'b00) tbl_ctr[up_idx] <= tbl_ctr[up_idx] - 2'b01;
                end
            end else if (up_hit) begin
                // A non-branch matched the entry: it was an alias, so drop it.
                tbl_valid[up_idx] <= 1'b0;
            end
        end
    end

    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc_i[1:0], head_pc[1:0]};

`ifdef BP_STATS_EN
    logic [31:0] br_cnt, miss_cnt;
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            br_cnt   <= 32'h0;
            miss_cnt <= 32'h0;
        end else begin
            if (pop && alu_branch_i) br_cnt <= br_cnt + 32'h1;
            if (mispredict)          miss_cnt <= miss_cnt + 32'h1;
        end
    end
    assign bp_br_cnt_o   = br_cnt;
    assign bp_miss_cnt_o = miss_cnt;
`else
    assign bp_br_cnt_o   = 32'h0;
    assign bp_miss_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: hand-derived vector table, reset corners, then random traffic
// against a table/queue model of the BTB.
module tb_branch_predictor;

    logic        clk;
    logic        rsn;
    logic [31:0] fetch_pc;
    logic        fetch_valid, flush, alu_valid, alu_branch, alu_jumps;
    logic [31:0] alu_pc_jmp;
    logic        bp_prediction, bp_taken, bp_error, bp_full;
    logic [31:0] bp_pred_pc, bp_br_cnt, bp_miss_cnt;

    branch_predictor dut (
        .clk_i          (clk),
        .rsn_i          (rsn),
        .fetch_pc_i     (fetch_pc),
        .fetch_valid_i  (fetch_valid),
        .flush_i        (flush),
        .alu_valid_i    (alu_valid),
        .alu_branch_i   (alu_branch),
        .alu_jumps_i    (alu_jumps),
        .alu_pc_jmp_i   (alu_pc_jmp),
        .bp_prediction_o(bp_prediction),
        .bp_taken_o     (bp_taken),
        .bp_pred_pc_o   (bp_pred_pc),
        .bp_error_o     (bp_error),
        .bp_full_o      (bp_full),
        .bp_br_cnt_o    (bp_br_cnt),
        .bp_miss_cnt_o  (bp_miss_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [31:0] pc;
        logic        fv, fl, av, br, jp;
        logic [31:0] jmp;
        logic        e_pred, e_taken;
        logic [31:0] e_ppc;
        logic        e_err, e_full;
    } vec_t;

    vec_t tbl[$];

    // ---------------- reference model ----------------
    // exp_q entries: {pc[31:0], pred_taken, pred_target[31:0]}
    logic [64:0] exp_q[$];
    bit          m_valid [16];
    int unsigned m_tag   [16];
    int          m_ctr   [16];
    logic [31:0] m_tgt   [16];
    int unsigned m_br, m_miss;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_ctr[i] = 1; m_tgt[i] = 32'h0;
        end
        exp_q.delete();
        m_br = 0; m_miss = 0;
    endtask

    task automatic model_lookup(input logic [31:0] pc, output logic hit, output logic tk,
                                output logic [31:0] tgt);
        int idx;
        idx = (pc / 4) % 16;
        hit = m_valid[idx] && (m_tag[idx] == pc / 64);
        tk  = hit && (m_ctr[idx] >= 2);
        tgt = hit ? m_tgt[idx] : 32'h0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle of inputs, compare at the falling edge, then advance the model past the rising edge.
    task automatic step(input bit use_tbl, input vec_t v);
        logic        e_hit, e_tk, e_err, e_full, h_tk, act, pop, push;
        logic [31:0] e_tgt, h_pc, h_tgt;
        int          idx;
        bit          hit;
        fetch_pc = v.pc; fetch_valid = v.fv; flush = v.fl; alu_valid = v.av;
        alu_branch = v.br; alu_jumps = v.jp; alu_pc_jmp = v.jmp;
        @(negedge clk);
        model_lookup(v.pc, e_hit, e_tk, e_tgt);
        h_pc  = exp_q.size() > 0 ? exp_q[0][64:33] : 32'h0;
        h_tk  = exp_q.size() > 0 ? exp_q[0][32]    : 1'b0;
        h_tgt = exp_q.size() > 0 ? exp_q[0][31:0]  : 32'h0;
        act   = v.br && v.jp;
        e_err = v.av && ((h_tk != act) || (h_tk && act && h_tgt != v.jmp));
        e_full = (exp_q.size() == 4);
        if (use_tbl) begin
            chk("prediction", 32'(bp_prediction), 32'(v.e_pred));
            chk("taken",      32'(bp_taken),      32'(v.e_taken));
            chk("pred_pc",    bp_pred_pc,         v.e_ppc);
            chk("error",      32'(bp_error),      32'(v.e_err));
            chk("full",       32'(bp_full),       32'(v.e_full));
        end else begin
            chk("prediction", 32'(bp_prediction), 32'(e_hit));
            chk("taken",      32'(bp_taken),      32'(e_tk));
            chk("pred_pc",    bp_pred_pc,         e_tgt);
            chk("error",      32'(bp_error),      32'(e_err));
            chk("full",       32'(bp_full),       32'(e_full));
        end
`ifdef BP_STATS_EN
        chk("br_cnt",   bp_br_cnt,   m_br);
        chk("miss_cnt", bp_miss_cnt, m_miss);
`else
        chk("br_cnt",   bp_br_cnt,   32'h0);
        chk("miss_cnt", bp_miss_cnt, 32'h0);
`endif
        // model next state
        pop  = v.av && (exp_q.size() > 0);
        push = v.fv && ((exp_q.size() < 4) || pop) && !v.fl && !e_err;
        if (pop) begin
            idx = (h_pc / 4) % 16;
            hit = m_valid[idx] && (m_tag[idx] == h_pc / 64);
            if (v.br) begin
                if (!hit) begin
                    m_valid[idx] = 1; m_tag[idx] = h_pc / 64; m_ctr[idx] = act ? 2 : 1;
                    if (act) m_tgt[idx] = v.jmp;
                end else if (act) begin
                    m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
                    m_tgt[idx] = v.jmp;
                end else begin
                    m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
                end
            end else if (hit) begin
                m_valid[idx] = 0;
            end
            if (v.br) m_br++;
        end
        if (e_err) m_miss++;
        if (v.fl || e_err) exp_q.delete();
        else begin
            if (pop)  void'(exp_q.pop_front());
            if (push) exp_q.push_back({v.pc, e_tk, e_tgt});
        end
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic [31:0] pc, logic fv, logic fl, logic av, logic br, logic jp,
                                logic [31:0] jmp, logic ep, logic et, logic [31:0] eppc,
                                logic ee, logic ef);
        vec_t v;
        v.pc = pc; v.fv = fv; v.fl = fl; v.av = av; v.br = br; v.jp = jp; v.jmp = jmp;
        v.e_pred = ep; v.e_taken = et; v.e_ppc = eppc; v.e_err = ee; v.e_full = ef;
        return v;
    endfunction

    task automatic do_reset();
        rsn = 1'b0;
        fetch_pc = 32'h1000; fetch_valid = 0; flush = 0; alu_valid = 0;
        alu_branch = 0; alu_jumps = 0; alu_pc_jmp = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_prediction", 32'(bp_prediction), 32'h0);
        chk("rst_taken",      32'(bp_taken),      32'h0);
        chk("rst_pred_pc",    bp_pred_pc,         32'h0);
        chk("rst_error",      32'(bp_error),      32'h0);
        chk("rst_full",       32'(bp_full),       32'h0);
        @(negedge clk);
        rsn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        //         pc        fv fl av br jp jmp        pred tk pred_pc    err full
        tbl.push_back(mk(32'h1010, 1, 0, 0, 0, 0, 32'h0,    0, 0, 32'h0,    0, 0));
        tbl.push_back(mk(32'h1010, 0, 0, 1, 1, 1, 32'h1100, 0, 0, 32'h0,    1, 0));
        tbl.push_back(mk(32'h1010, 1, 0, 0, 0, 0, 32'h0,    1, 1, 32'h1100, 0, 0));
        tbl.push_back(mk(32'h1010, 1, 0, 1, 1, 1, 32'h1100, 1, 1, 32'h1100, 0, 0));
        tbl.push_back(mk(32'h1010, 1, 0, 1, 1, 1, 32'h1100, 1, 1, 32'h1100, 0, 0));
        tbl.push_back(mk(32'h1010, 0, 0, 1, 1, 0, 32'h1100, 1, 1, 32'h1100, 1, 0));
        tbl.push_back(mk(32'h1010, 1, 0, 0, 0, 0, 32'h0,    1, 1, 32'h1100, 0, 0));
        tbl.push_back(mk(32'h1010, 0, 0, 1, 1, 1, 32'h1200, 1, 1, 32'h1100, 1, 0));
        tbl.push_back(mk(32'h1010, 0, 0, 0, 0, 0, 32'h0,    1, 1, 32'h1200, 0, 0));
        tbl.push_back(mk(32'h2000, 1, 0, 0, 0, 0, 32'h0,    0, 0, 32'h0,    0, 0));
        tbl.push_back(mk(32'h2004, 1, 0, 0, 0, 0, 32'h0,    0, 0, 32'h0,    0, 0));
        tbl.push_back(mk(32'h2008, 1, 0, 0, 0, 0, 32'h0,    0, 0, 32'h0,    0, 0));
        tbl.push_back(mk(32'h200c, 1, 0, 0, 0, 0, 32'h0,    0, 0, 32'h0,    0, 0));
        tbl.push_back(mk(32'h2010, 1, 0, 0, 0, 0, 32'h0,    0, 0, 32'h0,    0, 1));
        tbl.push_back(mk(32'h2014, 1, 0, 1, 0, 0, 32'h0,    0, 0, 32'h0,    0, 1));
        tbl.push_back(mk(32'h2014, 0, 0, 0, 0, 0, 32'h0,    0, 0, 32'h0,    0, 1));
        tbl.push_back(mk(32'h2018, 1, 1, 0, 0, 0, 32'h0,    0, 0, 32'h0,    0, 1));
        tbl.push_back(mk(32'h2018, 0, 0, 0, 0, 0, 32'h0,    0, 0, 32'h0,    0, 0));
        tbl.push_back(mk(32'h1020, 1, 0, 0, 0, 0, 32'h0,    0, 0, 32'h0,    0, 0));
        tbl.push_back(mk(32'h1020, 0, 0, 1, 1, 1, 32'h1300, 0, 0, 32'h0,    1, 0));
        tbl.push_back(mk(32'h1020, 1, 0, 0, 0, 0, 32'h0,    1, 1, 32'h1300, 0, 0));
        tbl.push_back(mk(32'h1020, 0, 0, 1, 0, 0, 32'h0,    1, 1, 32'h1300, 1, 0));
        tbl.push_back(mk(32'h1020, 0, 0, 0, 0, 0, 32'h0,    0, 0, 32'h0,    0, 0));
        tbl.push_back(mk(32'h1020, 0, 0, 1, 1, 1, 32'h1400, 0, 0, 32'h0,    1, 0));
        tbl.push_back(mk(32'h1020, 0, 0, 0, 0, 0, 32'h0,    0, 0, 32'h0,    0, 0));

        do_reset();
        foreach (tbl[i]) step(1'b1, tbl[i]);

        // Reset asserted mid-operation: table and queue vanish without waiting for an edge.
        step(1'b0, mk(32'h1010, 1, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0));
        step(1'b0, mk(32'h1010, 1, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0));
        fetch_pc = 32'h1010; fetch_valid = 0;
        #2 rsn = 1'b0;
        #1;
        chk("midrst_prediction", 32'(bp_prediction), 32'h0);
        chk("midrst_pred_pc",    bp_pred_pc,         32'h0);
        chk("midrst_full",       32'(bp_full),       32'h0);
        chk("midrst_miss_cnt",   bp_miss_cnt,        32'h0);
        model_reset();
        @(negedge clk);
        rsn = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic on a small PC/target pool so hits, aliases and saturation all occur.
        for (int n = 0; n < 600; n++) begin
            v = mk(32'h0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
            if ($urandom_range(0, 4) == 0) v.pc = 32'h2000 + ($urandom_range(0, 15) << 2);
            else                           v.pc = 32'h1000 + ($urandom_range(0, 23) << 2);
            v.fv  = ($urandom_range(0, 9) < 7);
            v.fl  = ($urandom_range(0, 19) == 0);
            v.av  = ($urandom_range(0, 9) < 5);
            v.br  = ($urandom_range(0, 9) < 7);
            v.jp  = $urandom_range(0, 1);
            v.jmp = 32'h3000 + ($urandom_range(0, 3) << 4);
            step(1'b0, v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
